// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state enum, arrow encodings and duration helper (LEFT_TURN_EN adds left states)
package traffic_pkg;

`ifdef LEFT_TURN_EN
    typedef enum logic [2:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_AMBER,
        ST_LEFT_GREEN,
        ST_LEFT_AMBER
    } phase_state_e;
`else
    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_AMBER
    } phase_state_e;
`endif

    localparam logic [1:0] ARROW_OFF   = 2'b00;
    localparam logic [1:0] ARROW_GREEN = 2'b01;
    localparam logic [1:0] ARROW_AMBER = 2'b10;

    // Seconds-counter value on whose tick an interval of dur seconds ends
    function automatic logic [15:0] last_count(input int dur);
        return 16'(dur - 1);
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// rtl/traffic_phase_sequencer_if.sv - request inputs and lamp outputs of the phase sequencer
interface traffic_phase_sequencer_if #(
    parameter int NUM_PHASES = 2
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  debug;
    logic [NUM_PHASES-1:0] walk_request;
    logic                  left_turn_request;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] amber;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] walk_light;
    logic [1:0]            left_turn;
    logic [IDX_W-1:0]      phase_idx;

    modport master (
        output debug, walk_request, left_turn_request,
        input  green, amber, red, walk_light, left_turn, phase_idx
    );

    modport slave (
        input  debug, walk_request, left_turn_request,
        output green, amber, red, walk_light, left_turn, phase_idx
    );
endinterface

// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - one-second tick prescaler with debug fast-tick mode
module traffic_tick_gen #(
    parameter int TICK_DIV = 27000000
) (
    input  logic clk_27,
    input  logic reset,
    input  logic debug,
    output logic tick
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             debug_q, debug_d;

    // Debug mode is only re-sampled on a tick so a tick interval is never cut short
    always_comb begin
        tick    = debug_q || (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + 1'b1;
        debug_d = tick ? debug : debug_q;
    end

    // Divider and sampled debug mode registers
    always_ff @(posedge clk_27 or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            debug_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            debug_q <= debug_d;
        end
    end
endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - rotating through-phase sequencer with walk service; LEFT_TURN_EN adds the protected left arrow
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int TICK_DIV   = 27000000,
    parameter int GREEN_S    = 10,
    parameter int AMBER_S    = 3,
    parameter int ALLRED_S   = 1,
    parameter int WALK_S     = 6,
    parameter int LEFT_S     = 5,
    parameter int LEFT_PHASE = 0
) (
    input  logic                     clk_27,
    input  logic                     reset,
    traffic_phase_sequencer_if.slave sif
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(NUM_PHASES - 1);

    typedef logic [NUM_PHASES-1:0] lamp_t;

    function automatic lamp_t phase_bit(input logic [IDX_W-1:0] idx);
        return lamp_t'(1) << idx;
    endfunction

    logic             tick;
    phase_state_e     state_q, state_d;
    logic [IDX_W-1:0] phase_q, phase_d, next_phase;
    logic [15:0]      sec_q, sec_d;
    lamp_t            latch_q, latch_d, req_all;
    lamp_t            walk_q, walk_d;
    lamp_t            green_q, green_d, amber_q, amber_d, red_q, red_d;
    logic [1:0]       arrow_q, arrow_d;

`ifdef LEFT_TURN_EN
    localparam logic [IDX_W-1:0] LEFT_IDX = IDX_W'(LEFT_PHASE);
    logic left_latch_q, left_latch_d, left_done_q, left_done_d, left_req;
`else
    logic unused_left;
    assign unused_left = sif.left_turn_request ^ (LEFT_S == LEFT_PHASE);
`endif

    traffic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_27 (clk_27),
        .reset  (reset),
        .debug  (sif.debug),
        .tick   (tick)
    );

    // Next state, request latches and lamp decode; lamps follow the next state so they land one cycle after the ending tick
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sec_d      = sec_q;
        req_all    = latch_q | sif.walk_request;
        latch_d    = req_all;
        walk_d     = walk_q;
        next_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
`ifdef LEFT_TURN_EN
        left_req     = left_latch_q | sif.left_turn_request;
        left_latch_d = left_req;
        left_done_d  = left_done_q;
`endif
        if (tick) begin
            sec_d = sec_q + 1'b1;
            case (state_q)
                ST_ALLRED: begin
                    if (sec_q == last_count(ALLRED_S)) begin
                        sec_d = '0;
`ifdef LEFT_TURN_EN
                        if (left_req && !left_done_q && next_phase == LEFT_IDX) begin
                            state_d = ST_LEFT_GREEN;
                        end else
`endif
                        begin
                            // A request sampled in this entry cycle is served now and cleared
                            state_d = ST_GREEN;
                            phase_d = next_phase;
                            walk_d  = req_all & phase_bit(next_phase);
                            latch_d = req_all & ~phase_bit(next_phase);
                        end
                    end
                end
                ST_GREEN: begin
                    if (sec_q == last_count(GREEN_S)) begin
                        state_d = ST_AMBER;
                        sec_d   = '0;
                        walk_d  = '0;
                    end else if (sec_q == last_count(WALK_S)) begin
                        walk_d = '0;
                    end
                end
                ST_AMBER: begin
                    if (sec_q == last_count(AMBER_S)) begin
                        state_d = ST_ALLRED;
                        sec_d   = '0;
                    end
                end
`ifdef LEFT_TURN_EN
                ST_LEFT_GREEN: begin
                    if (sec_q == last_count(LEFT_S)) begin
                        state_d = ST_LEFT_AMBER;
                        sec_d   = '0;
                    end
                end
                ST_LEFT_AMBER: begin
                    if (sec_q == last_count(AMBER_S)) begin
                        state_d = ST_ALLRED;
                        sec_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = ST_ALLRED;
                    sec_d   = '0;
                    walk_d  = '0;
                end
            endcase
        end
`ifdef LEFT_TURN_EN
        // left_done keeps the ALLRED after the arrow from re-entering it before the through green
        if (state_q == ST_ALLRED && state_d == ST_LEFT_GREEN) begin
            left_latch_d = 1'b0;
            left_done_d  = 1'b1;
        end else if (state_q == ST_ALLRED && state_d == ST_GREEN) begin
            left_done_d = 1'b0;
        end
`endif
        green_d = '0;
        amber_d = '0;
        arrow_d = ARROW_OFF;
        case (state_d)
            ST_GREEN:      green_d = phase_bit(phase_d);
            ST_AMBER:      amber_d = phase_bit(phase_d);
`ifdef LEFT_TURN_EN
            ST_LEFT_GREEN: arrow_d = ARROW_GREEN;
            ST_LEFT_AMBER: arrow_d = ARROW_AMBER;
`endif
            default:       ;
        endcase
        red_d = ~(green_d | amber_d);
    end

    // Sequencer state and registered lamp outputs; reset drops straight to all-red
    always_ff @(posedge clk_27 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ALLRED;
            phase_q <= LAST_PHASE;
            sec_q   <= '0;
            latch_q <= '0;
            walk_q  <= '0;
            green_q <= '0;
            amber_q <= '0;
            red_q   <= '1;
            arrow_q <= ARROW_OFF;
`ifdef LEFT_TURN_EN
            left_latch_q <= 1'b0;
            left_done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sec_q   <= sec_d;
            latch_q <= latch_d;
            walk_q  <= walk_d;
            green_q <= green_d;
            amber_q <= amber_d;
            red_q   <= red_d;
            arrow_q <= arrow_d;
`ifdef LEFT_TURN_EN
            left_latch_q <= left_latch_d;
            left_done_q  <= left_done_d;
`endif
        end
    end

    assign sif.green      = green_q;
    assign sif.amber      = amber_q;
    assign sif.red        = red_q;
    assign sif.walk_light = walk_q;
    assign sif.left_turn  = arrow_q;
    assign sif.phase_idx  = phase_q;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for traffic_phase_sequencer (LEFT_TURN_EN aware)
module tb_traffic_phase_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer_if #(.NUM_PHASES(3)) tif ();

    traffic_phase_sequencer #(
        .NUM_PHASES(3), .TICK_DIV(4), .GREEN_S(5), .AMBER_S(2), .ALLRED_S(1),
        .WALK_S(3), .LEFT_S(2), .LEFT_PHASE(0)
    ) dut (
        .clk_27 (clk),
        .reset  (rst_n),
        .sif    (tif)
    );

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] a;
        logic [2:0] r;
        logic [2:0] w;
        logic [1:0] l;
        logic [1:0] p;
    } lamps_t;

    typedef struct packed {
        lamps_t      o;
        logic [15:0] len;
    } seg_t;

    seg_t exp_q[$];

    function automatic logic [2:0] oh(input int p);
        return 3'b001 << p;
    endfunction

    task automatic push(input logic [2:0] g, input logic [2:0] a, input logic [2:0] r,
                        input logic [2:0] w, input logic [1:0] l, input int p, input int len);
        seg_t s;
        s.o.g = g; s.o.a = a; s.o.r = r; s.o.w = w; s.o.l = l;
        s.o.p = 2'(p);
        s.len = 16'(len);
        exp_q.push_back(s);
    endtask

    // green (optionally split by walk), amber, allred of phase p; k = cycles per tick
    task automatic push_rot(input int p, input bit walk, input int k);
        logic [2:0] m;
        m = oh(p);
        if (walk) begin
            push(m, 3'b0, ~m, m, 2'b0, p, 3 * k);
            push(m, 3'b0, ~m, 3'b0, 2'b0, p, 2 * k);
        end else begin
            push(m, 3'b0, ~m, 3'b0, 2'b0, p, 5 * k);
        end
        push(3'b0, m, ~m, 3'b0, 2'b0, p, 2 * k);
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, p, k);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_red", 8'(tif.red), 8'b111);
        chk("rst_green", 8'(tif.green), 8'b0);
        chk("rst_amber", 8'(tif.amber), 8'b0);
        chk("rst_walk", 8'(tif.walk_light), 8'b0);
        chk("rst_arrow", 8'(tif.left_turn), 8'b0);
        chk("rst_phase", 8'(tif.phase_idx), 8'd2);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mon_en = 1'b0;
        tif.debug = 1'b0;
        tif.walk_request = 3'b0;
        tif.left_turn_request = 1'b0;
        #1;
        chk_reset_state();
        cycles(2);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycles(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d segments pending after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Monitor: every lamp change closes a segment that is scored against the next expected one
    lamps_t cur;
    lamps_t obs;
    int     cur_len;
    bit     cur_valid = 1'b0;
    seg_t   e;

    always @(negedge clk) begin
        if (!mon_en) begin
            cur_valid = 1'b0;
        end else begin
            checks++;
            if ((tif.green & tif.amber) != 3'b0 || tif.red != ~(tif.green | tif.amber)
                || $countones(~tif.red) > 1 || (tif.walk_light & ~tif.green) != 3'b0) begin
                errors++;
                $display("FAIL lamp_excl: got g=%b a=%b r=%b w=%b, required one lamp per phase and at most one phase non-red",
                         tif.green, tif.amber, tif.red, tif.walk_light);
            end
            obs = {tif.green, tif.amber, tif.red, tif.walk_light, tif.left_turn, tif.phase_idx};
            if (!cur_valid) begin
                cur = obs;
                cur_len = 1;
                cur_valid = 1'b1;
            end else if (obs == cur) begin
                cur_len++;
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seg_extra: got g=%b a=%b r=%b w=%b arrow=%b ph=%0d len=%0d, required no segment",
                             cur.g, cur.a, cur.r, cur.w, cur.l, cur.p, cur_len);
                end else begin
                    e = exp_q.pop_front();
                    if (e.o != cur || e.len != 16'(cur_len)) begin
                        errors++;
                        $display("FAIL seg: got g=%b a=%b r=%b w=%b arrow=%b ph=%0d len=%0d, required g=%b a=%b r=%b w=%b arrow=%b ph=%0d len=%0d",
                                 cur.g, cur.a, cur.r, cur.w, cur.l, cur.p, cur_len,
                                 e.o.g, e.o.a, e.o.r, e.o.w, e.o.l, e.o.p, e.len);
                    end
                end
                cur = obs;
                cur_len = 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.debug = 1'b0;
        tif.walk_request = 3'b0;
        tif.left_turn_request = 1'b0;
        cycles(2);
        chk_reset_state();

        // Basic rotation with wrap-around back to phase 0
        apply_reset();
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push_rot(0, 1'b0, 4);
        push_rot(1, 1'b0, 4);
        push_rot(2, 1'b0, 4);
        push(3'b001, 3'b0, 3'b110, 3'b0, 2'b0, 0, 20);
        release_reset();
        drain(200);

        // Debug mode: first tick still uses the divider, then one tick per cycle
        apply_reset();
        tif.debug = 1'b1;
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push_rot(0, 1'b0, 1);
        push_rot(1, 1'b0, 1);
        release_reset();
        drain(60);

        // Reset asserted mid-amber, then a clean restart
        apply_reset();
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push(3'b001, 3'b0, 3'b110, 3'b0, 2'b0, 0, 20);
        release_reset();
        drain(60);
        cycles(2);
        chk("mid_amber_pre", 8'(tif.amber), 8'b001);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("async_red", 8'(tif.red), 8'b111);
        chk("async_amber", 8'(tif.amber), 8'b0);
        chk("async_green", 8'(tif.green), 8'b0);
        cycles(2);
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push_rot(0, 1'b0, 4);
        push(3'b010, 3'b0, 3'b101, 3'b0, 2'b0, 1, 20);
        release_reset();
        drain(120);

        // Walk: pulse for phase 1 during phase 0 green, re-request after phase 1 entry
        apply_reset();
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push_rot(0, 1'b0, 4);
        push_rot(1, 1'b1, 4);
        push_rot(2, 1'b0, 4);
        push_rot(0, 1'b0, 4);
        push_rot(1, 1'b1, 4);
        push_rot(2, 1'b0, 4);
        push_rot(0, 1'b0, 4);
        push_rot(1, 1'b0, 4);
        release_reset();
        cycles(10);
        tif.walk_request = 3'b010;
        cycles(1);
        tif.walk_request = 3'b000;
        cycles(29);
        tif.walk_request = 3'b010;
        cycles(1);
        tif.walk_request = 3'b000;
        drain(400);

        // Left-arrow request during phase 2 green
        apply_reset();
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b0, 2, 4);
        push_rot(0, 1'b0, 4);
        push_rot(1, 1'b0, 4);
        push_rot(2, 1'b0, 4);
`ifdef LEFT_TURN_EN
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b01, 2, 8);
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b10, 2, 8);
        push(3'b0, 3'b0, 3'b111, 3'b0, 2'b00, 2, 4);
`endif
        push_rot(0, 1'b0, 4);
        release_reset();
        cycles(70);
        tif.left_turn_request = 1'b1;
        cycles(1);
        tif.left_turn_request = 1'b0;
        drain(300);

        mon_en = 1'b0;
        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PHASES, default 2, number of mutually exclusive through phases (legal 2..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 27000000, clk_27 cycles per one-second tick.
REQ-003 The block SHALL have parameters GREEN_S 10, AMBER_S 3, ALLRED_S 1, WALK_S 6, LEFT_S 5 (seconds); all >=1, WALK_S<=GREEN_S.
REQ-004 The block SHALL have parameter LEFT_PHASE, default 0, the phase that owns the protected left arrow.
REQ-005 clk_27  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 debug  in  1  high: one tick per clk_27 cycle instead of per TICK_DIV cycles.
REQ-008 walk_request  in  NUM_PHASES  per-phase pedestrian request, level or pulse.
REQ-009 left_turn_request  in  1  left-arrow request for LEFT_PHASE.
REQ-010 green, amber, red  out  NUM_PHASES each  active-high through-phase lamps.
REQ-011 walk_light  out  NUM_PHASES  active-high walk indication.
REQ-012 left_turn  out  2  arrow: 2'b00 off, 2'b01 green, 2'b10 amber.
REQ-013 phase_idx  out  clog2(NUM_PHASES)  current phase index.

Function
REQ-014 A prescaler SHALL emit a one-cycle tick every TICK_DIV cycles (every cycle when debug=1); a debug change takes effect at the next tick boundary.
REQ-015 States: ALLRED, GREEN, AMBER, and with LEFT_TURN_EN also LEFT_GREEN, LEFT_AMBER.
REQ-016 A seconds counter SHALL advance on each tick and the state SHALL change on the tick at which it equals duration-1, then restart at 0.
REQ-017 Transitions: ALLRED(ALLRED_S) -> GREEN of phase_idx+1 mod NUM_PHASES -> AMBER(AMBER_S) -> ALLRED.
REQ-018 Wrap-around: after phase NUM_PHASES-1, phase_idx SHALL return to 0.
REQ-019 In GREEN, green[phase_idx]=1, others' red=1; in AMBER, amber[phase_idx]=1; in ALLRED, red all ones; exactly one of green/amber/red per phase at all times.
REQ-020 All outputs SHALL be registered; lamps change on the cycle after the ending tick (latency 1).
REQ-021 walk_request[i] SHALL be latched sticky until served.
REQ-022 On entry to GREEN of phase i with latch[i]=1, walk_light[i] SHALL be high for exactly WALK_S seconds and latch[i] SHALL clear in the entry cycle.
REQ-023 A request sampled in the entry cycle SHALL count as served; one arriving later in that green SHALL remain latched for the next rotation.
REQ-024 walk_light SHALL be low in AMBER, ALLRED and left states.

Reset
REQ-025 Reset assertion SHALL immediately (asynchronously) force red all ones, green/amber/walk_light zero, left_turn 2'b00.
REQ-026 Reset SHALL force state ALLRED, phase_idx NUM_PHASES-1, counters and request latches zero, so phase 0 is first green.
REQ-027 Reset mid-operation SHALL abandon the current interval with no amber completion.

Configuration
REQ-028 Macro LEFT_TURN_EN defined: latched left_turn_request SHALL insert LEFT_GREEN(LEFT_S) -> LEFT_AMBER(AMBER_S) -> ALLRED before GREEN of LEFT_PHASE, with all through lamps red, and clear the latch on LEFT_GREEN entry.
REQ-029 Macro LEFT_TURN_EN undefined: left_turn_request ignored, left_turn constant 2'b00, left states absent.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the state enum and arrow encodings (ARROW_OFF, ARROW_GREEN, ARROW_AMBER).
REQ-031 The prescaler SHALL be sub-module traffic_tick_gen (clk_27, reset, debug, tick).

Verification (NUM_PHASES=3, TICK_DIV=4, GREEN_S=5, AMBER_S=2, ALLRED_S=1, WALK_S=3, LEFT_S=2)
REQ-032 Release reset -> red=3'b111 for 4 cycles, then green=3'b001 for 20 cycles, amber=3'b001 for 8, red=3'b111 for 4, green=3'b010.
REQ-033 Full run past phase 2 -> phase_idx sequence 0,1,2,0 with no two phases non-red simultaneously.
REQ-034 Pulse walk_request[1] during phase 0 green -> walk_light[1] high 12 cycles from green[1] entry, latch clear; pulse during its own green after entry -> served next rotation.
REQ-035 debug=1 -> GREEN 5 cycles, AMBER 2, ALLRED 1.
REQ-036 Assert reset mid-AMBER -> red=3'b111, amber=0 within same cycle; restart as REQ-032.
REQ-037 LEFT_TURN_EN, pulse left_turn_request during phase 2 green -> left_turn=2'b01 for 8 cycles, 2'b10 for 8, ALLRED 4, then green=3'b001; without macro left_turn stays 2'b00.
